router_ctrl_fsm: RTL and testbench

//  Packet-level control FSM of the 1x3 router; sits directly upstream of the sync stage.
//  - Decodes the header address and gates header/payload/parity loading into the selected output FIFO.
//  - Drives detect_add and write_enb_reg to the sync stage.
//  - Consumes fifo_full and soft_reset_0..2 back from the sync stage.
//  - Raises busy so the source holds its data.

---
 rtl/router_ctrl_fsm.sv | 114 +++++++++++
 tb/tb_router_ctrl_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/router_ctrl_fsm.sv
// Packet-level control FSM of the 1x3 router: decodes the header address and sequences header/payload/parity loads.
// Moore machine; every output decodes from the state register alone. busy holds the source off while it cannot accept data.
module router_ctrl_fsm (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     r_state;
    logic [1:0] r_addr;

    logic [2:0] w_empty;
    logic [2:0] w_soft;
    logic       w_sel_empty;
    logic       w_sel_soft;
    logic       w_hdr_ok;

    assign w_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft  = {soft_reset_2, soft_reset_1, soft_reset_0};

    // Address 3 never reaches the latch, so r_addr always indexes a real port.
    assign w_sel_empty = w_empty[r_addr];
    assign w_sel_soft  = w_soft[r_addr];
    assign w_hdr_ok    = pkt_valid && (data_in != 2'd3);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
        end else begin
            if (r_state == DECODE_ADDRESS && w_hdr_ok)
                r_addr <= data_in;

            if (w_sel_soft) begin
                r_state <= DECODE_ADDRESS;
            end else begin
                case (r_state)
                    DECODE_ADDRESS: begin
                        if (w_hdr_ok)
                            r_state <= w_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                    WAIT_TILL_EMPTY: begin
                        if (w_sel_empty)
                            r_state <= LOAD_FIRST_DATA;
                    end
                    LOAD_FIRST_DATA: r_state <= LOAD_DATA;
                    LOAD_DATA: begin
                        if (fifo_full)
                            r_state <= FIFO_FULL_STATE;
                        else if (!pkt_valid)
                            r_state <= LOAD_PARITY;
                    end
                    FIFO_FULL_STATE: begin
                        if (!fifo_full)
                            r_state <= LOAD_AFTER_FULL;
                    end
                    LOAD_AFTER_FULL: begin
                        if (parity_done)
                            r_state <= DECODE_ADDRESS;
                        else if (low_pkt_valid)
                            r_state <= LOAD_PARITY;
                        else
                            r_state <= LOAD_DATA;
                    end
                    LOAD_PARITY: r_state <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR: begin
                        r_state <= fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                    end
                    default: r_state <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign detect_add    = (r_state == DECODE_ADDRESS);
    assign lfd_state     = (r_state == LOAD_FIRST_DATA);
    assign ld_state      = (r_state == LOAD_DATA);
    assign laf_state     = (r_state == LOAD_AFTER_FULL);
    assign full_state    = (r_state == FIFO_FULL_STATE);
    assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                           (r_state == LOAD_AFTER_FULL);
    assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm: stimulus queues hand-derived expected outputs, a negedge monitor compares them.
module tb_router_ctrl_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       rst_int_reg, write_enb_reg, busy;

    always #5 clock = ~clock;

    router_ctrl_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .write_enb_reg (write_enb_reg),
        .busy          (busy)
    );

    // Output vector order: detect_add lfd ld laf full rst_int write_enb busy
    localparam logic [7:0] E_DA   = 8'b1000_0000;
    localparam logic [7:0] E_LFD  = 8'b0100_0001;
    localparam logic [7:0] E_LD   = 8'b0010_0010;
    localparam logic [7:0] E_LAF  = 8'b0001_0011;
    localparam logic [7:0] E_FULL = 8'b0000_1001;
    localparam logic [7:0] E_CHK  = 8'b0000_0101;
    localparam logic [7:0] E_LP   = 8'b0000_0011;
    localparam logic [7:0] E_WAIT = 8'b0000_0001;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0] w_obs;
    assign w_obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                    rst_int_reg, write_enb_reg, busy};

    // Monitor: one expected entry per clock, compared half a cycle after the edge.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            checks++;
            if (w_obs !== e.exp) begin
                errors++;
                $display("FAIL %s: outputs got %b want %b", e.tag, w_obs, e.exp);
            end
        end
    end

    // Apply the currently driven inputs across one rising edge and queue the expected result.
    task automatic tick(input logic [7:0] exp, input string tag);
        sb_t e;
        @(posedge clock);
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        #1;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
        parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;

        tick(E_DA, "reset0");
        tick(E_DA, "reset1");
        resetn = 1'b1;
        tick(E_DA, "idle");

        // Normal packet to port 1, four payload bytes
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(E_LFD, "p1_lfd");
        tick(E_LD, "p1_ld1");
        tick(E_LD, "p1_ld2");
        tick(E_LD, "p1_ld3");
        tick(E_LD, "p1_ld4");
        pkt_valid = 1'b0;
        tick(E_LP, "p1_parity");
        tick(E_CHK, "p1_check");
        tick(E_DA, "p1_done");

        // Port 2 busy draining: wait, then load
        pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        tick(E_WAIT, "p2_wait");
        tick(E_WAIT, "p2_wait_hold");
        fifo_empty_2 = 1'b1;
        tick(E_LFD, "p2_lfd");
        tick(E_LD, "p2_ld");

        // FIFO full in LD, then LAF -> LOAD_PARITY
        fifo_full = 1'b1;
        tick(E_FULL, "full_enter");
        tick(E_FULL, "full_hold");
        fifo_full = 1'b0;
        tick(E_LAF, "laf_a");
        low_pkt_valid = 1'b1;
        tick(E_LP, "laf_to_lp");
        low_pkt_valid = 1'b0; pkt_valid = 1'b0;
        tick(E_CHK, "laf_check");
        tick(E_DA, "laf_a_done");

        // LAF -> DECODE on parity_done
        pkt_valid = 1'b1; data_in = 2'd0;
        tick(E_LFD, "p0_lfd");
        tick(E_LD, "p0_ld");
        fifo_full = 1'b1;
        tick(E_FULL, "p0_full");
        fifo_full = 1'b0;
        tick(E_LAF, "laf_b");
        parity_done = 1'b1;
        tick(E_DA, "laf_to_da");
        parity_done = 1'b0;

        // LAF -> LD when neither; full beats pkt_valid drop in LD
        tick(E_LFD, "p0b_lfd");
        tick(E_LD, "p0b_ld");
        fifo_full = 1'b1;
        tick(E_FULL, "p0b_full");
        fifo_full = 1'b0;
        tick(E_LAF, "laf_c");
        tick(E_LD, "laf_to_ld");
        pkt_valid = 1'b0; fifo_full = 1'b1;
        tick(E_FULL, "full_over_pv");
        fifo_full = 1'b0;
        tick(E_LAF, "laf_d");
        parity_done = 1'b1;
        tick(E_DA, "laf_d_done");
        parity_done = 1'b0;

        // CHECK_PARITY_ERROR with FIFO full -> FIFO_FULL_STATE
        pkt_valid = 1'b1; data_in = 2'd1;
        tick(E_LFD, "p1b_lfd");
        tick(E_LD, "p1b_ld");
        pkt_valid = 1'b0;
        tick(E_LP, "p1b_lp");
        fifo_full = 1'b1;
        tick(E_CHK, "p1b_check");
        tick(E_FULL, "check_to_full");
        fifo_full = 1'b0;
        tick(E_LAF, "p1b_laf");
        parity_done = 1'b1;
        tick(E_DA, "p1b_done");
        parity_done = 1'b0;

        // Soft reset: non-selected port ignored, selected port aborts
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b0;
        tick(E_WAIT, "sr_wait");
        pkt_valid = 1'b0; soft_reset_1 = 1'b1;
        tick(E_WAIT, "sr_other_port");
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick(E_DA, "sr_selected");
        soft_reset_0 = 1'b0; fifo_empty_0 = 1'b1;
        tick(E_DA, "sr_idle");

        // Invalid address 3 is dropped
        pkt_valid = 1'b1; data_in = 2'd3;
        tick(E_DA, "addr3_a");
        tick(E_DA, "addr3_b");

        // Reset in the middle of a packet
        data_in = 2'd2;
        tick(E_LFD, "mid_lfd");
        tick(E_LD, "mid_ld");
        resetn = 1'b0;
        tick(E_DA, "mid_reset");
        resetn = 1'b1; pkt_valid = 1'b0;
        tick(E_DA, "mid_after");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++)
            @(negedge clock);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
